uart_display_arbiter: RTL
=========================

# uart_display_arbiter

- Shares the board's four-digit seven-segment display between the UART receive path and the UART transmit path.
- Latches the most recent byte from each side and grants the display round-robin, with a minimum on-screen hold time.
- Converts the granted byte to three BCD digits sequentially using shift-add-3, one bit per cycle.
- Drives a 16-bit digit bus to the existing seven-segment driver: digit a shows the source tag, digits b/c/d show hundreds/tens/ones.

## Interface
- HOLD_CYCLES, 50_000_000, minimum cycles a granted byte stays displayed before another grant; legal range ≥ 1
- HOLD_W, 26, width of the hold counter; must satisfy 2^HOLD_W > HOLD_CYCLES-1
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
- rx_data  input  8  received byte, sampled when rx_valid=1
- tx_valid  input  1  one-cycle strobe: tx_data holds a transmitted byte
- tx_data  input  8  transmitted byte, sampled when tx_valid=1
- rx_ack  output  1  one-cycle pulse: pending RX byte granted
- tx_ack  output  1  one-cycle pulse: pending TX byte granted
- disp_digits  output  16  {src tag, hundreds, tens, ones}, one BCD nibble each
- disp_src  output  1  0 = RX shown, 1 = TX shown
- disp_valid  output  1  high once a first conversion has completed
- busy  output  1  high whenever the state is not IDLE

## Operation
- Pending slots: one per source, each a flag plus an 8-bit byte.
  - A valid strobe sets the flag and overwrites the byte; the latest byte wins and no queueing is done.
  - A valid on the same edge that grants that source is kept as new pending data, not lost.
- State machine: IDLE, CONV, HOLD.
- IDLE:
  - With no flag set, stay in IDLE.
  - With one or more flags set, grant one source: clear its flag, load its byte into the shift register, clear the BCD accumulator, bit_cnt=0, register its ack for the next cycle, go to CONV.
- Arbitration when both flags are set: grant the source not served last. last_src resets to TX, so RX wins the first tie.
- CONV runs 8 cycles. Each cycle:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {bcd, byte} left by one.
  - bit_cnt+1.
- On the 8th CONV edge:
  - disp_digits = {tag, H, T, O}, with tag 4'h1 for RX and 4'h2 for TX.
  - Set disp_src.
  - disp_valid=1.
  - hold_cnt=HOLD_CYCLES-1.
  - Go to HOLD.
- HOLD: decrement hold_cnt each edge; on the edge where hold_cnt==0, go to IDLE. disp_digits is unchanged in HOLD and IDLE.
- Arithmetic: the 8-bit input gives a 12-bit BCD result. Hundreds ≤ 2 and each nibble ≤ 9 for every input 0..255.

## Timing
- Reset values: disp_digits=16'h0000, disp_src=0, disp_valid=0, rx_ack=0, tx_ack=0, busy=0, both flags clear, state IDLE, last_src=TX.
- Reset takes effect immediately and asynchronously from any state.
  - An in-flight conversion is discarded and pending bytes are cleared.
  - No ack is issued after release unless a new valid arrives.
- Latency, with the block in IDLE:
  - Valid sampled at edge k → grant at edge k+1.
  - Ack high during cycle k+1..k+2.
  - disp_digits updated at edge k+9.
- Grant-to-grant period: exactly 1 + 8 + HOLD_CYCLES cycles when the other source is pending.
- busy is high from the grant edge until the edge that returns to IDLE.
- Valid strobes are accepted in every state. rx_valid and tx_valid on the same edge both set their flags.

## Test plan
- Reset: hold reset=0 for 3 cycles and release → all outputs at their reset values, no ack pulse for 20 cycles.
- Single RX, HOLD_CYCLES=4: rx_valid with rx_data=8'd255 → rx_ack one cycle, then at +9 edges disp_digits=16'h1255, disp_src=0, disp_valid=1; busy drops 4 cycles later.
- Simultaneous valids: rx 8'd7 and tx 8'd128 on the same edge → 16'h1007 first; tx_ack and 16'h2128 follow exactly 13 cycles later.
- Overwrite: while RX is held, tx 8'd10 then tx 8'd200 → a single tx_ack, display shows 16'h2200, and 10 is never shown.
- Boundaries: RX 8'd0 → 16'h1000; RX 8'd99 → 16'h1099; RX 8'd100 → 16'h1100.
- Reset mid-CONV: assert reset 3 cycles into CONV → immediate 16'h0000 and disp_valid=0; after release, idle with no ack.

Source files
------------

// File: rtl/uart_display_arbiter.sv
// uart_display_arbiter
//   Shares one four-digit seven-segment display between the UART RX and TX
//   paths. Each side has a single "latest byte wins" pending slot. Slots are
//   granted round-robin. The granted byte is converted to BCD by
//   shift-add-3, one bit per cycle, and then held on screen for at least
//   HOLD_CYCLES cycles.
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous active-low reset
//   rx_valid / rx_data  one-cycle strobe plus received byte
//   tx_valid / tx_data  one-cycle strobe plus transmitted byte
//   rx_ack / tx_ack     one-cycle pulse, the cycle after a source is granted
//   disp_digits         {source tag, hundreds, tens, ones}
//   disp_src            0 = RX shown, 1 = TX shown
//   disp_valid          high once a first conversion has completed
//   busy                high whenever the arbiter is not idle
module uart_display_arbiter #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int HOLD_W      = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        rx_ack,
  output logic        tx_ack,
  output logic [15:0] disp_digits,
  output logic        disp_src,
  output logic        disp_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Source encoding shared by cur_src and last_src: 0 = RX, 1 = TX.
  localparam logic SRC_RX = 1'b0;
  localparam logic SRC_TX = 1'b1;

  // Add 3 to a BCD nibble that would overflow past 9 once it is doubled.
  function automatic logic [3:0] nib_adj(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // One shift-add-3 step over {bcd[11:0], byte[7:0]}.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] a;
    a = {nib_adj(v[19:16]), nib_adj(v[15:12]), nib_adj(v[11:8]), v[7:0]};
    return {a[18:0], 1'b0};
  endfunction

  state_t           state_q, state_d;
  logic             rx_flag_q, rx_flag_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             tx_flag_q, tx_flag_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             last_src_q, last_src_d;
  logic             cur_src_q, cur_src_d;
  logic [7:0]       shift_q, shift_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]      disp_digits_q, disp_digits_d;
  logic             disp_src_q, disp_src_d;
  logic             disp_valid_q, disp_valid_d;
  logic             rx_ack_q, rx_ack_d;
  logic             tx_ack_q, tx_ack_d;
  logic             busy_q, busy_d;
  logic             grant_rx_s, grant_tx_s;
  logic [19:0]      step_s;

  // Next-state, arbitration, conversion datapath and pending-slot update.
  always_comb begin
    state_d       = state_q;
    rx_flag_d     = rx_flag_q;
    rx_byte_d     = rx_byte_q;
    tx_flag_d     = tx_flag_q;
    tx_byte_d     = tx_byte_q;
    last_src_d    = last_src_q;
    cur_src_d     = cur_src_q;
    shift_d       = shift_q;
    bcd_d         = bcd_q;
    bit_cnt_d     = bit_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    disp_digits_d = disp_digits_q;
    disp_src_d    = disp_src_q;
    disp_valid_d  = disp_valid_q;
    rx_ack_d      = 1'b0;
    tx_ack_d      = 1'b0;
    grant_rx_s    = 1'b0;
    grant_tx_s    = 1'b0;
    step_s        = dd_step({bcd_q, shift_q});

    case (state_q)
      ST_IDLE: begin
        // On a tie, the source not served last wins.
        if (rx_flag_q && (!tx_flag_q || (last_src_q == SRC_TX))) begin
          grant_rx_s = 1'b1;
          cur_src_d  = SRC_RX;
          last_src_d = SRC_RX;
          shift_d    = rx_byte_q;
          bcd_d      = 12'h000;
          bit_cnt_d  = 3'd0;
          rx_ack_d   = 1'b1;
          state_d    = ST_CONV;
        end else if (tx_flag_q) begin
          grant_tx_s = 1'b1;
          cur_src_d  = SRC_TX;
          last_src_d = SRC_TX;
          shift_d    = tx_byte_q;
          bcd_d      = 12'h000;
          bit_cnt_d  = 3'd0;
          tx_ack_d   = 1'b1;
          state_d    = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        bcd_d     = step_s[19:8];
        shift_d   = step_s[7:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          disp_digits_d = {((cur_src_q == SRC_TX) ? 4'h2 : 4'h1), step_s[19:8]};
          disp_src_d    = cur_src_q;
          disp_valid_d  = 1'b1;
          hold_cnt_d    = HOLD_W'(HOLD_CYCLES - 1);
          state_d       = ST_HOLD;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          state_d    = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A strobe on the granting edge takes priority over the grant's clear,
    // so the new byte stays pending.
    if (rx_valid) begin
      rx_flag_d = 1'b1;
      rx_byte_d = rx_data;
    end else if (grant_rx_s) begin
      rx_flag_d = 1'b0;
    end else begin
      rx_flag_d = rx_flag_q;
    end

    if (tx_valid) begin
      tx_flag_d = 1'b1;
      tx_byte_d = tx_data;
    end else if (grant_tx_s) begin
      tx_flag_d = 1'b0;
    end else begin
      tx_flag_d = tx_flag_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rx_flag_q     <= 1'b0;
      rx_byte_q     <= 8'h00;
      tx_flag_q     <= 1'b0;
      tx_byte_q     <= 8'h00;
      last_src_q    <= SRC_TX;
      cur_src_q     <= SRC_RX;
      shift_q       <= 8'h00;
      bcd_q         <= 12'h000;
      bit_cnt_q     <= 3'd0;
      hold_cnt_q    <= '0;
      disp_digits_q <= 16'h0000;
      disp_src_q    <= 1'b0;
      disp_valid_q  <= 1'b0;
      rx_ack_q      <= 1'b0;
      tx_ack_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_flag_q     <= rx_flag_d;
      rx_byte_q     <= rx_byte_d;
      tx_flag_q     <= tx_flag_d;
      tx_byte_q     <= tx_byte_d;
      last_src_q    <= last_src_d;
      cur_src_q     <= cur_src_d;
      shift_q       <= shift_d;
      bcd_q         <= bcd_d;
      bit_cnt_q     <= bit_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      disp_digits_q <= disp_digits_d;
      disp_src_q    <= disp_src_d;
      disp_valid_q  <= disp_valid_d;
      rx_ack_q      <= rx_ack_d;
      tx_ack_q      <= tx_ack_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_ack      = rx_ack_q;
  assign tx_ack      = tx_ack_q;
  assign disp_digits = disp_digits_q;
  assign disp_src    = disp_src_q;
  assign disp_valid  = disp_valid_q;
  assign busy        = busy_q;

endmodule
